ysyx_23060059_axi_arbiter: RTL and testbench
============================================

# ysyx_23060059_axi_arbiter

Two-master, one-slave AXI4 arbiter that shares the single memory-side AXI port between the instruction fetch unit (read-only master) and the load/store unit (read/write master). It sits between the IFU/LSU AXI master ports and the SoC/memory AXI slave port. It grants exactly one transaction at a time and holds the grant until that transaction's response completes. Every signal is routed combinationally from a registered grant state.

## Interface
Parameters:
- PRIO_LSU, default 1, simultaneous-read policy:
  - 1: LSU always wins.
  - 0: round-robin, the master not granted last wins.

Ports (clock and reset first):
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ifu_araddr/arid/arlen/arsize/arburst  in  32/4/8/3/2  IFU read-address payload.
- ifu_arvalid  in  1  IFU read request.
- ifu_arready  out  1  IFU read-address accept.
- ifu_rdata/rresp/rlast/rid  out  64/2/1/4  IFU read-data payload.
- ifu_rvalid  out  1  IFU read-data valid.
- ifu_rready  in  1  IFU read-data accept.
- lsu_ar*, lsu_r*  same widths and directions as the ifu_ equivalents  LSU read channels.
- lsu_awaddr/awid/awlen/awsize/awburst  in  32/4/8/3/2  LSU write-address payload.
- lsu_awvalid  in  1  LSU write request.
- lsu_awready  out  1  LSU write-address accept.
- lsu_wdata/wstrb/wlast  in  64/8/1  LSU write-data payload.
- lsu_wvalid  in  1  LSU write-data valid.
- lsu_wready  out  1  LSU write-data accept.
- lsu_bresp/bid  out  2/4  LSU write-response payload.
- lsu_bvalid  out  1  LSU write-response valid.
- lsu_bready  in  1  LSU write-response accept.
- ar*, r*, aw*, w*, b*  mirror directions  slave-side AXI4 port (master role toward memory), same widths.
- arb_state  out  2  current state: 0 IDLE, 1 IFU_RD, 2 LSU_RD, 3 LSU_WR.

## Operation
- State register, reset value IDLE.
- IDLE decision, evaluated in priority order:
  - lsu_awvalid → LSU_WR.
  - Else, lsu_arvalid and ifu_arvalid both high → winner per PRIO_LSU.
  - Else, lsu_arvalid → LSU_RD.
  - Else, ifu_arvalid → IFU_RD.
  - Else stay in IDLE.
- Round-robin bookkeeping:
  - last_grant register: 0 = IFU, 1 = LSU; reset value 0.
  - Updated to the granted master on every IDLE exit.
- IDLE outputs: all slave valids/readies 0; all master readies/valids 0; payload outputs 0.
- IFU_RD:
  - Slave ar* = ifu_ar*; ifu_arready = arready.
  - ifu_r* = slave r*; rready = ifu_rready.
  - All other master handshakes 0; slave awvalid/wvalid/bready 0.
  - Exit to IDLE on rvalid && rready && rlast.
- LSU_RD: same as IFU_RD with lsu_ ports. Exit on rvalid && rready && rlast.
- LSU_WR:
  - Slave aw*/w* = lsu_aw*/lsu_w*; lsu_awready = awready; lsu_wready = wready.
  - lsu_b* = slave b*; bready = lsu_bready.
  - Exit on bvalid && bready.
- A request not granted is simply left pending. Masters must hold valid/payload stable (AXI rule); the arbiter keeps no copy of the request.
- Bursts (arlen > 0): grant is held until the beat with rlast.
- rresp/bresp are forwarded unmodified. Non-OKAY responses are the masters' concern.

## Timing
- Arbitration latency: one cycle.
  - A request arriving in IDLE at cycle N changes state at edge N+1.
  - Slave arvalid/awvalid is visible during cycle N+1.
- Back-to-back: the exit handshake at cycle M returns to IDLE at M+1. The next grant is visible at M+2 (one idle bubble minimum).
- Response exit and a new request in the same cycle: the new request is only evaluated from IDLE, never chained directly.
- All routing is combinational from state.
  - No added latency on accepted beats.
  - ready/valid pass through with zero cycles.
- Grant changes only on a completed response handshake, never mid-transaction, regardless of new requests.
- Reset asserted mid-transaction:
  - State returns to IDLE at the next edge and last_grant is cleared to 0.
  - All outputs go to their IDLE values (0).
  - The in-flight transaction is abandoned; the slave is reset with the same reset.

## Test plan
- Lone IFU read, araddr=0x80000000, arlen=0: arb_state 1 one cycle after arvalid. ifu_rdata receives the slave's 0x00000013_00000297. State is IDLE one cycle after the rlast handshake.
- Simultaneous IFU and LSU reads, PRIO_LSU=1, three times in a row: LSU granted all three times, IFU granted afterwards. With PRIO_LSU=0 and reset last_grant=0: order is LSU, IFU, LSU.
- LSU write, awaddr=0xa00003f8, wstrb=0x0f, wdata=0x41: the slave sees aw and w in the same cycle. lsu_bvalid mirrors bvalid, and bresp=2 is forwarded unchanged. IFU arvalid held throughout gets no arready until the state returns to IDLE.
- IFU burst, arlen=3, with LSU arvalid raised on beat 1: the grant stays IFU for all 4 beats. The LSU is granted 2 cycles after the last beat's handshake.
- Slave arready held low for 5 cycles: the grant stays put and the payload stays stable. Both ifu_arready and lsu_arready stay 0 for the non-granted master.
- Reset pulse during LSU_RD before the r beat: arb_state = 0 and all slave valids = 0 on the following cycle. The first request after reset is arbitrated normally.

Source files
------------

// File: rtl/ysyx_23060059_axi_arbiter.sv
// ysyx_23060059_axi_arbiter: shares one AXI4 slave port between the IFU (read-only) and LSU (read/write),
// one transaction at a time, routing every channel combinationally from the registered grant.
module ysyx_23060059_axi_arbiter #(
    parameter int PRIO_LSU = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ifu_araddr,
    input  logic [3:0]  ifu_arid,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [63:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic [3:0]  ifu_rid,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    input  logic [31:0] lsu_araddr,
    input  logic [3:0]  lsu_arid,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    input  logic [1:0]  lsu_arburst,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [63:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rlast,
    output logic [3:0]  lsu_rid,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic [3:0]  lsu_awid,
    input  logic [7:0]  lsu_awlen,
    input  logic [2:0]  lsu_awsize,
    input  logic [1:0]  lsu_awburst,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wstrb,
    input  logic        lsu_wlast,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic [3:0]  lsu_bid,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic [3:0]  bid,
    input  logic        bvalid,
    output logic        bready,
    output logic [1:0]  arb_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, IFU_RD = 2'd1, LSU_RD = 2'd2, LSU_WR = 2'd3} state_e;
    state_e state_q;
    logic   last_grant_q;
    logic   ifu_g, lsu_g, wr_g, lsu_wins;
    assign ifu_g    = state_q == IFU_RD;
    assign lsu_g    = state_q == LSU_RD;
    assign wr_g     = state_q == LSU_WR;
    // Round-robin favours whichever master was not granted last; LSU priority overrides it.
    assign lsu_wins = (PRIO_LSU != 0) || !last_grant_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_awvalid) begin
                        state_q      <= LSU_WR;
                        last_grant_q <= 1'b1;
                    end else if (lsu_arvalid && (!ifu_arvalid || lsu_wins)) begin
                        state_q      <= LSU_RD;
                        last_grant_q <= 1'b1;
                    end else if (ifu_arvalid) begin
                        state_q      <= IFU_RD;
                        last_grant_q <= 1'b0;
                    end
                end
                IFU_RD, LSU_RD: if (rvalid && rready && rlast) state_q <= IDLE;
                LSU_WR: if (bvalid && bready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign arb_state = state_q;
    assign araddr  = ifu_g ? ifu_araddr  : lsu_g ? lsu_araddr  : '0;
    assign arid    = ifu_g ? ifu_arid    : lsu_g ? lsu_arid    : '0;
    assign arlen   = ifu_g ? ifu_arlen   : lsu_g ? lsu_arlen   : '0;
    assign arsize  = ifu_g ? ifu_arsize  : lsu_g ? lsu_arsize  : '0;
    assign arburst = ifu_g ? ifu_arburst : lsu_g ? lsu_arburst : '0;
    assign arvalid = ifu_g ? ifu_arvalid : lsu_g && lsu_arvalid;
    assign rready  = ifu_g ? ifu_rready  : lsu_g && lsu_rready;
    assign ifu_arready = ifu_g && arready;
    assign ifu_rdata   = ifu_g ? rdata : '0;
    assign ifu_rresp   = ifu_g ? rresp : '0;
    assign ifu_rlast   = ifu_g && rlast;
    assign ifu_rid     = ifu_g ? rid : '0;
    assign ifu_rvalid  = ifu_g && rvalid;
    assign lsu_arready = lsu_g && arready;
    assign lsu_rdata   = lsu_g ? rdata : '0;
    assign lsu_rresp   = lsu_g ? rresp : '0;
    assign lsu_rlast   = lsu_g && rlast;
    assign lsu_rid     = lsu_g ? rid : '0;
    assign lsu_rvalid  = lsu_g && rvalid;
    assign awaddr  = wr_g ? lsu_awaddr  : '0;
    assign awid    = wr_g ? lsu_awid    : '0;
    assign awlen   = wr_g ? lsu_awlen   : '0;
    assign awsize  = wr_g ? lsu_awsize  : '0;
    assign awburst = wr_g ? lsu_awburst : '0;
    assign awvalid = wr_g && lsu_awvalid;
    assign wdata   = wr_g ? lsu_wdata   : '0;
    assign wstrb   = wr_g ? lsu_wstrb   : '0;
    assign wlast   = wr_g && lsu_wlast;
    assign wvalid  = wr_g && lsu_wvalid;
    assign bready  = wr_g && lsu_bready;
    assign lsu_awready = wr_g && awready;
    assign lsu_wready  = wr_g && wready;
    assign lsu_bresp   = wr_g ? bresp : '0;
    assign lsu_bid     = wr_g ? bid : '0;
    assign lsu_bvalid  = wr_g && bvalid;
endmodule

// File: tb/tb_ysyx_23060059_axi_arbiter.sv
// tb_ysyx_23060059_axi_arbiter: runs a PRIO_LSU=0 and a PRIO_LSU=1 arbiter side by side on shared
// stimulus, checking every cycle against a transaction-level ownership model of the arbitration rules.
module tb_ysyx_23060059_axi_arbiter;
    logic clk = 1'b0, reset;
    always #5 clk = ~clk;
    logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr;
    logic [3:0]  ifu_arid, lsu_arid, lsu_awid, rid, bid;
    logic [7:0]  ifu_arlen, lsu_arlen, lsu_awlen, lsu_wstrb;
    logic [2:0]  ifu_arsize, lsu_arsize, lsu_awsize;
    logic [1:0]  ifu_arburst, lsu_arburst, lsu_awburst, rresp, bresp;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wlast, lsu_wvalid, lsu_bready;
    logic [63:0] lsu_wdata, rdata;
    logic        arready, rlast, rvalid, awready, wready, bvalid;
    logic        ifu_arready [2], ifu_rlast [2], ifu_rvalid [2], lsu_arready [2], lsu_rlast [2], lsu_rvalid [2];
    logic [63:0] ifu_rdata [2], lsu_rdata [2], s_wdata [2];
    logic [1:0]  ifu_rresp [2], lsu_rresp [2], lsu_bresp [2], s_arburst [2], s_awburst [2], st [2];
    logic [3:0]  ifu_rid [2], lsu_rid [2], lsu_bid [2], s_arid [2], s_awid [2];
    logic        lsu_awready [2], lsu_wready [2], lsu_bvalid [2];
    logic [31:0] s_araddr [2], s_awaddr [2];
    logic [7:0]  s_arlen [2], s_awlen [2], s_wstrb [2];
    logic [2:0]  s_arsize [2], s_awsize [2];
    logic        s_arvalid [2], s_rready [2], s_awvalid [2], s_wlast [2], s_wvalid [2], s_bready [2];
    for (genvar p = 0; p < 2; p++) begin : g_dut
        ysyx_23060059_axi_arbiter #(.PRIO_LSU(p)) u_dut (
            .clock(clk), .reset(reset),
            .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
            .ifu_arburst(ifu_arburst), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready[p]),
            .ifu_rdata(ifu_rdata[p]), .ifu_rresp(ifu_rresp[p]), .ifu_rlast(ifu_rlast[p]), .ifu_rid(ifu_rid[p]),
            .ifu_rvalid(ifu_rvalid[p]), .ifu_rready(ifu_rready),
            .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
            .lsu_arburst(lsu_arburst), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready[p]),
            .lsu_rdata(lsu_rdata[p]), .lsu_rresp(lsu_rresp[p]), .lsu_rlast(lsu_rlast[p]), .lsu_rid(lsu_rid[p]),
            .lsu_rvalid(lsu_rvalid[p]), .lsu_rready(lsu_rready),
            .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize),
            .lsu_awburst(lsu_awburst), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready[p]),
            .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wvalid(lsu_wvalid),
            .lsu_wready(lsu_wready[p]), .lsu_bresp(lsu_bresp[p]), .lsu_bid(lsu_bid[p]),
            .lsu_bvalid(lsu_bvalid[p]), .lsu_bready(lsu_bready),
            .araddr(s_araddr[p]), .arid(s_arid[p]), .arlen(s_arlen[p]), .arsize(s_arsize[p]),
            .arburst(s_arburst[p]), .arvalid(s_arvalid[p]), .arready(arready),
            .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(s_rready[p]),
            .awaddr(s_awaddr[p]), .awid(s_awid[p]), .awlen(s_awlen[p]), .awsize(s_awsize[p]),
            .awburst(s_awburst[p]), .awvalid(s_awvalid[p]), .awready(awready),
            .wdata(s_wdata[p]), .wstrb(s_wstrb[p]), .wlast(s_wlast[p]), .wvalid(s_wvalid[p]), .wready(wready),
            .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(s_bready[p]),
            .arb_state(st[p])
        );
    end
    int checks = 0, failures = 0;
    int own [2], lg [2];
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic quiet();
        {ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst, ifu_arvalid, ifu_rready} = '0;
        {lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize, lsu_arburst, lsu_arvalid, lsu_rready} = '0;
        {lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst, lsu_awvalid} = '0;
        {lsu_wdata, lsu_wstrb, lsu_wlast, lsu_wvalid, lsu_bready} = '0;
        {arready, rdata, rresp, rlast, rid, rvalid, awready, wready, bresp, bid, bvalid} = '0;
    endtask
    // Ownership model: 0 none, 1 IFU read, 2 LSU read, 3 LSU write; lg is the last granted master (1 = LSU).
    task automatic step();
        logic [127:0] e_ar, e_aw, e_ir, e_lr, e_wb;
        int n_own, n_lg;
        bit done;
        #1;
        for (int p = 0; p < 2; p++) begin
            e_ar = own[p] == 1 ? {ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst, ifu_arvalid, ifu_rready}
                 : own[p] == 2 ? {lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize, lsu_arburst, lsu_arvalid, lsu_rready} : '0;
            e_aw = own[p] == 3 ? {lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst, lsu_awvalid,
                                  lsu_wdata, lsu_wstrb, lsu_wlast, lsu_wvalid, lsu_bready} : '0;
            e_ir = own[p] == 1 ? {arready, rdata, rresp, rlast, rid, rvalid} : '0;
            e_lr = own[p] == 2 ? {arready, rdata, rresp, rlast, rid, rvalid} : '0;
            e_wb = own[p] == 3 ? {awready, wready, bresp, bid, bvalid} : '0;
            check($sformatf("state%0d", p), 128'(st[p]), 128'(own[p]));
            check($sformatf("slv_ar%0d", p),
                  {s_araddr[p], s_arid[p], s_arlen[p], s_arsize[p], s_arburst[p], s_arvalid[p], s_rready[p]}, e_ar);
            check($sformatf("slv_aw%0d", p), {s_awaddr[p], s_awid[p], s_awlen[p], s_awsize[p], s_awburst[p],
                  s_awvalid[p], s_wdata[p], s_wstrb[p], s_wlast[p], s_wvalid[p], s_bready[p]}, e_aw);
            check($sformatf("ifu_r%0d", p),
                  {ifu_arready[p], ifu_rdata[p], ifu_rresp[p], ifu_rlast[p], ifu_rid[p], ifu_rvalid[p]}, e_ir);
            check($sformatf("lsu_r%0d", p),
                  {lsu_arready[p], lsu_rdata[p], lsu_rresp[p], lsu_rlast[p], lsu_rid[p], lsu_rvalid[p]}, e_lr);
            check($sformatf("lsu_b%0d", p),
                  {lsu_awready[p], lsu_wready[p], lsu_bresp[p], lsu_bid[p], lsu_bvalid[p]}, e_wb);
        end
        for (int p = 0; p < 2; p++) begin
            n_own = own[p];
            n_lg = lg[p];
            if (own[p] == 0) begin
                if (lsu_awvalid) begin n_own = 3; n_lg = 1; end
                else if (lsu_arvalid && ifu_arvalid) begin
                    n_lg = (p == 1 || lg[p] == 0) ? 1 : 0;
                    n_own = n_lg == 1 ? 2 : 1;
                end
                else if (lsu_arvalid) begin n_own = 2; n_lg = 1; end
                else if (ifu_arvalid) begin n_own = 1; n_lg = 0; end
            end else begin
                done = own[p] == 3 ? (bvalid && lsu_bready)
                     : (rvalid && rlast && (own[p] == 1 ? ifu_rready : lsu_rready));
                if (done) n_own = 0;
            end
            if (reset) begin n_own = 0; n_lg = 0; end
            own[p] = n_own;
            lg[p] = n_lg;
        end
        @(posedge clk);
        @(negedge clk);
    endtask
    initial begin
        int g1 [3], g0 [3];
        quiet();
        own = '{0, 0};
        lg = '{0, 0};
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        // lone IFU read
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; arready = 1'b1; ifu_rready = 1'b1;
        step();
        #1 check("ifu_grant", 128'(st[1]), 128'd1);
        check("ifu_araddr", 128'(s_araddr[1]), 128'h8000_0000);
        step();
        ifu_arvalid = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 64'h0000_0013_0000_0297;
        #1 check("ifu_rdata", 128'(ifu_rdata[1]), 128'h0000_0013_0000_0297);
        step();
        rvalid = 1'b0;
        #1 check("ifu_done", 128'(st[1]), 128'd0);
        // simultaneous reads, answered immediately
        quiet();
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; arready = 1'b1; rvalid = 1'b1; rlast = 1'b1;
        ifu_rready = 1'b1; lsu_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            g1[i] = int'(st[1]);
            g0[i] = int'(st[0]);
            step();
        end
        check("prio_seq", {g1[0][1:0], g1[1][1:0], g1[2][1:0]}, {2'd2, 2'd2, 2'd2});
        check("rr_seq", {g0[0][1:0], g0[1][1:0], g0[2][1:0]}, {2'd2, 2'd1, 2'd2});
        lsu_arvalid = 1'b0;
        step();
        #1 check("ifu_after", 128'(st[1]), 128'd1);
        step();
        // LSU write with IFU read held pending
        quiet();
        ifu_arvalid = 1'b1; arready = 1'b1;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'ha000_03f8; lsu_wvalid = 1'b1; lsu_wstrb = 8'h0f;
        lsu_wdata = 64'h41; lsu_wlast = 1'b1; awready = 1'b1; wready = 1'b1; lsu_bready = 1'b1;
        step();
        #1 check("aw_w_same", {s_awvalid[1], s_wvalid[1], ifu_arready[1]}, 3'b110);
        step();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; bvalid = 1'b1; bresp = 2'd2;
        #1 check("bresp_fwd", {lsu_bvalid[1], lsu_bresp[1], ifu_arready[1]}, 4'b1100);
        step();
        bvalid = 1'b0;
        step();
        #1 check("ifu_late", {st[1], ifu_arready[1]}, 3'b011);
        // IFU burst of 4 beats with LSU arriving on beat 1
        quiet();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ifu_arvalid = 1'b1; ifu_arlen = 8'd3; arready = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
        step();
        ifu_arvalid = 1'b0; rvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            rlast = b == 3;
            lsu_arvalid = b >= 1;
            #1 check($sformatf("burst_b%0d", b), 128'(st[1]), 128'd1);
            step();
        end
        rvalid = 1'b0; rlast = 1'b0;
        step();
        #1 check("lsu_after_burst", 128'(st[1]), 128'd2);
        // arready stalled for 5 cycles, then reset mid LSU_RD
        arready = 1'b0; ifu_arvalid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1 check("rst_mid", {st[1], s_arvalid[1], s_awvalid[1]}, 4'b0000);
        step();
        #1 check("post_rst_grant", 128'(st[1]), 128'd2);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 59) == 0;
            ifu_araddr = $urandom; ifu_arid = 4'($urandom); ifu_arlen = 8'($urandom); ifu_arsize = 3'($urandom);
            ifu_arburst = 2'($urandom); ifu_arvalid = $urandom_range(0, 2) != 0; ifu_rready = $urandom_range(0, 3) != 0;
            lsu_araddr = $urandom; lsu_arid = 4'($urandom); lsu_arlen = 8'($urandom); lsu_arsize = 3'($urandom);
            lsu_arburst = 2'($urandom); lsu_arvalid = $urandom_range(0, 1) != 0; lsu_rready = $urandom_range(0, 3) != 0;
            lsu_awaddr = $urandom; lsu_awid = 4'($urandom); lsu_awlen = 8'($urandom); lsu_awsize = 3'($urandom);
            lsu_awburst = 2'($urandom); lsu_awvalid = $urandom_range(0, 4) == 0;
            lsu_wdata = {$urandom, $urandom}; lsu_wstrb = 8'($urandom); lsu_wlast = 1'($urandom);
            lsu_wvalid = 1'($urandom); lsu_bready = $urandom_range(0, 3) != 0;
            arready = 1'($urandom); rdata = {$urandom, $urandom}; rresp = 2'($urandom); rlast = 1'($urandom);
            rid = 4'($urandom); rvalid = 1'($urandom); awready = 1'($urandom); wready = 1'($urandom);
            bresp = 2'($urandom); bid = 4'($urandom); bvalid = $urandom_range(0, 2) == 0;
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
